// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline-control types and opcodes used by the decoder and the hazard controller.
// Pure declarations, no logic.
package riscv_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] J      = 7'b1101111;
  localparam logic [6:0] JR     = 7'b1100111;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: the slave modport is the controller, the master the pipeline around it.
// Pure wiring, no latency.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              ex_memread;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_redirect;
  logic              mem_req;
  logic              dmem_ready;
  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              back_write;
  logic              mem_error;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd, ex_redirect, mem_req, dmem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, back_write, mem_error, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd, ex_redirect, mem_req, dmem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, back_write, mem_error, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use detector: ID reads a register that the load in EX has not produced yet.
// Purely combinational; x0 is never a hazard since it is never written.
module load_use_detect
  import riscv_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              hazard
);
  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
  assign hazard  = ex_memread && (ex_rd != REG_AW'(REG_ZERO)) && (rs1_hit || rs2_hit);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: stage enables/flushes for load-use, EX redirects and slow dmem; zero added latency.
// A dmem wait freezes the whole pipe; a wait longer than MEM_TIMEOUT cycles locks into ERROR until reset.
module pipeline_hazard_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int               WCW       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0]   WAIT_LAST = WCW'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  hz_state_e        state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             mem_error_q, mem_error_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic hazard;
  logic pc_w, if_id_w, if_id_f, id_ex_f, back_w, redirect_flush;

  load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .id_rs1     (hz.id_rs1),
    .id_rs2     (hz.id_rs2),
    .id_use_rs1 (hz.id_use_rs1),
    .id_use_rs2 (hz.id_use_rs2),
    .ex_memread (hz.ex_memread),
    .ex_rd      (hz.ex_rd),
    .hazard     (hazard)
  );

  always_comb begin
    pc_w           = 1'b0;
    if_id_w        = 1'b0;
    if_id_f        = 1'b0;
    id_ex_f        = 1'b0;
    back_w         = 1'b0;
    redirect_flush = 1'b0;
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    mem_error_d    = mem_error_q;
    case (state_q)
      RUN: begin
        if (hz.mem_req && !hz.dmem_ready) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WCW'(1);
        end else if (hz.ex_redirect) begin
          // Redirect beats load-use: the ID instruction is squashed either way.
          pc_w           = 1'b1;
          if_id_w        = 1'b1;
          back_w         = 1'b1;
          if_id_f        = 1'b1;
          id_ex_f        = 1'b1;
          redirect_flush = 1'b1;
        end else if (hazard) begin
          id_ex_f = 1'b1;
          back_w  = 1'b1;
        end else begin
          pc_w    = 1'b1;
          if_id_w = 1'b1;
          back_w  = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (hz.dmem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d     = ERROR;
          mem_error_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      ERROR:   mem_error_d = 1'b1;
      default: state_d = RUN;
    endcase

    stall_cnt_d = (!pc_w && stall_cnt_q != CNT_MAX) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (redirect_flush && flush_cnt_q != CNT_MAX) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_error_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Held in reset, every enable and flush is forced low regardless of inputs.
  assign hz.pc_write    = rst_n && pc_w;
  assign hz.if_id_write = rst_n && if_id_w;
  assign hz.if_id_flush = rst_n && if_id_f;
  assign hz.id_ex_flush = rst_n && id_ex_f;
  assign hz.back_write  = rst_n && back_w;
  assign hz.mem_error   = mem_error_q;
  assign hz.stall_cnt   = stall_cnt_q;
  assign hz.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: per-cycle expected outputs queued with the stimulus, popped at negedge.
module tb_pipeline_hazard_ctrl;
  localparam int REG_AW      = 5;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;

  // Output vector: {pc_write, if_id_write, if_id_flush, id_ex_flush, back_write, mem_error}
  localparam logic [5:0] O_RUN = 6'b110010;
  localparam logic [5:0] O_FRZ = 6'b000000;
  localparam logic [5:0] O_ERR = 6'b000001;
  localparam logic [5:0] O_RDR = 6'b111110;
  localparam logic [5:0] O_LU  = 6'b000110;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       mr;
    logic [4:0] rd;
    logic       rdr;
    logic       mreq;
    logic       rdy;
    logic [5:0] e;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hz ();

  pipeline_hazard_ctrl #(.REG_AW(REG_AW), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  logic [5:0]       exp_q[$];
  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] m_stall = '0;
  logic [CNT_W-1:0] m_flush = '0;

  function automatic logic [5:0] obs();
    return {hz.pc_write, hz.if_id_write, hz.if_id_flush, hz.id_ex_flush, hz.back_write, hz.mem_error};
  endfunction

  function automatic stim_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                               input logic mr, input logic [4:0] rd, input logic rdr, input logic mreq,
                               input logic rdy, input logic [5:0] e);
    stim_t s;
    s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2; s.mr = mr; s.rd = rd;
    s.rdr = rdr; s.mreq = mreq; s.rdy = rdy; s.e = e;
    return s;
  endfunction

  task automatic set_inputs(input stim_t s);
    hz.id_rs1 = s.rs1; hz.id_rs2 = s.rs2; hz.id_use_rs1 = s.u1; hz.id_use_rs2 = s.u2;
    hz.ex_memread = s.mr; hz.ex_rd = s.rd; hz.ex_redirect = s.rdr;
    hz.mem_req = s.mreq; hz.dmem_ready = s.rdy;
  endtask

  task automatic drive(input stim_t s);
    @(posedge clk);
    #1;
    set_inputs(s);
    exp_q.push_back(s.e);
    @(negedge clk);
  endtask

  task automatic model_step(input logic [5:0] e);
    if (rst_n) begin
      if (!e[5] && m_stall != '1) m_stall = m_stall + 1'b1;
      if (e[3] && m_flush != '1) m_flush = m_flush + 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_inputs(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_stall = '0;
    m_flush = '0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    stim_t t[$];
    logic [5:0] e;
    rst_n = 1'b0;
    set_inputs(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_FRZ));
    repeat (2) @(negedge clk);
    checks++;
    if (obs() !== O_FRZ || hz.stall_cnt !== '0 || hz.flush_cnt !== '0) begin
      errors++;
      $display("FAIL reset_hold: got outs=%b stall=%0d flush=%0d want outs=%b stall=0 flush=0",
               obs(), hz.stall_cnt, hz.flush_cnt, O_FRZ);
    end
    // Inputs that would normally redirect must still leave everything low in reset.
    set_inputs(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ));
    #1;
    checks++;
    if (obs() !== O_FRZ) begin
      errors++;
      $display("FAIL reset_gate: got outs=%b want %b", obs(), O_FRZ);
    end
    do_reset();
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
    foreach (t[i]) begin
      drive(t[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL reset[%0d] outs: got %b want %b", i, obs(), e); end
      checks++;
      if (hz.stall_cnt !== m_stall || hz.flush_cnt !== m_flush) begin
        errors++;
        $display("FAIL reset[%0d] counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                 i, hz.stall_cnt, hz.flush_cnt, m_stall, m_flush);
      end
      model_step(e);
    end
  endtask

  task automatic test_load_use();
    stim_t t[$];
    logic [5:0] e;
    do_reset();
    t.push_back(mk(3, 5, 1, 1, 1, 5, 0, 0, 0, O_LU));   // rs2 hit
    t.push_back(mk(3, 5, 1, 1, 0, 0, 0, 0, 0, O_RUN));  // EX now a bubble
    t.push_back(mk(7, 2, 1, 0, 1, 7, 0, 0, 0, O_LU));   // rs1 hit
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
    t.push_back(mk(1, 9, 1, 0, 1, 9, 0, 0, 0, O_RUN));  // rs2 matches but unused
    t.push_back(mk(4, 6, 1, 1, 0, 4, 0, 0, 0, O_RUN));  // not a load
    t.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, O_RUN));  // x0 filter
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
    foreach (t[i]) begin
      drive(t[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL load_use[%0d] outs: got %b want %b", i, obs(), e); end
      checks++;
      if (hz.stall_cnt !== m_stall || hz.flush_cnt !== m_flush) begin
        errors++;
        $display("FAIL load_use[%0d] counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                 i, hz.stall_cnt, hz.flush_cnt, m_stall, m_flush);
      end
      model_step(e);
    end
  endtask

  task automatic test_redirect();
    stim_t t[$];
    logic [5:0] e;
    do_reset();
    t.push_back(mk(5, 0, 1, 0, 1, 5, 1, 0, 0, O_RDR));  // redirect + load-use
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_RDR));  // plain redirect
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
    foreach (t[i]) begin
      drive(t[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL redirect[%0d] outs: got %b want %b", i, obs(), e); end
      checks++;
      if (hz.stall_cnt !== m_stall || hz.flush_cnt !== m_flush) begin
        errors++;
        $display("FAIL redirect[%0d] counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                 i, hz.stall_cnt, hz.flush_cnt, m_stall, m_flush);
      end
      model_step(e);
    end
  endtask

  task automatic test_mem_wait();
    stim_t t[$];
    logic [5:0] e;
    do_reset();
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, O_FRZ));  // ready, still frozen this cycle
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, O_RUN));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, O_FRZ));  // freeze outranks redirect
    t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, O_FRZ));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_RDR));  // held redirect acted on
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
    foreach (t[i]) begin
      drive(t[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL mem_wait[%0d] outs: got %b want %b", i, obs(), e); end
      checks++;
      if (hz.stall_cnt !== m_stall || hz.flush_cnt !== m_flush) begin
        errors++;
        $display("FAIL mem_wait[%0d] counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                 i, hz.stall_cnt, hz.flush_cnt, m_stall, m_flush);
      end
      model_step(e);
    end
  endtask

  task automatic test_timeout();
    stim_t t[$];
    logic [5:0] e;
    do_reset();
    for (int k = 0; k < MEM_TIMEOUT; k++) t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ));
    for (int k = 0; k < 8; k++) t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_ERR));
    for (int k = 0; k < 6; k++) t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, O_ERR));  // only reset exits
    foreach (t[i]) begin
      drive(t[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL timeout[%0d] outs: got %b want %b", i, obs(), e); end
      checks++;
      if (hz.stall_cnt !== m_stall || hz.flush_cnt !== m_flush) begin
        errors++;
        $display("FAIL timeout[%0d] counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                 i, hz.stall_cnt, hz.flush_cnt, m_stall, m_flush);
      end
      model_step(e);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== O_FRZ || hz.stall_cnt !== '0) begin
      errors++;
      $display("FAIL timeout_reset_pulse: got outs=%b stall=%0d want outs=%b stall=0", obs(), hz.stall_cnt, O_FRZ);
    end
  endtask

  task automatic test_back_to_back();
    stim_t t[$];
    logic [5:0] e;
    do_reset();
    // Reset lands mid-wait: nothing of the pending access survives.
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_FRZ));
    foreach (t[i]) begin
      drive(t[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL pre_reset[%0d] outs: got %b want %b", i, obs(), e); end
      model_step(e);
    end
    t.delete();
    do_reset();
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
    for (int k = 0; k < 18; k++) t.push_back(mk(2, 0, 1, 0, 1, 2, 1, 0, 0, O_RDR));
    t.push_back(mk(2, 0, 1, 0, 1, 2, 0, 0, 0, O_LU));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_RDR));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
    foreach (t[i]) begin
      drive(t[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs() !== e) begin errors++; $display("FAIL back_to_back[%0d] outs: got %b want %b", i, obs(), e); end
      checks++;
      if (hz.stall_cnt !== m_stall || hz.flush_cnt !== m_flush) begin
        errors++;
        $display("FAIL back_to_back[%0d] counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                 i, hz.stall_cnt, hz.flush_cnt, m_stall, m_flush);
      end
      model_step(e);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
